// File: rtl/uart_rx_core.sv
// UART receive core: synchronizes rx_in, validates the start bit, mid-bit samples
// DATA_BITS data bits LSB-first and checks the stop bit on OVERSAMPLE x baud ticks.
module uart_rx_core #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 inp_clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_ZERO  = {BW{1'b0}};
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_DATA     = 3'd2,
        ST_STOP     = 3'd3,
        ST_BRK_WAIT = 3'd4
    } state_t;

    state_t                 state_r,      state_s;
    logic [TW-1:0]          tick_cnt_r,   tick_cnt_s;
    logic [BW-1:0]          bit_cnt_r,    bit_cnt_s;
    logic [DATA_BITS-1:0]   shift_r,      shift_s;
    logic [DATA_BITS-1:0]   data_out_r,   data_out_s;
    logic                   data_valid_r, data_valid_s;
    logic                   frame_err_r,  frame_err_s;
    logic                   sync1_r;
    logic                   sync2_r;
    logic                   rx_sync_s;

    assign rx_sync_s  = sync2_r;
    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign frame_err  = frame_err_r;
    assign busy       = (state_r != ST_IDLE);

    // Two-flop synchronizer on the asynchronous line, running every clock.
    always_ff @(posedge inp_clk) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= rx_in;
            sync2_r <= sync1_r;
        end
    end

    // Next-state and datapath decode; nothing moves without a baud tick.
    always_comb begin
        state_s      = state_r;
        tick_cnt_s   = tick_cnt_r;
        bit_cnt_s    = bit_cnt_r;
        shift_s      = shift_r;
        data_out_s   = data_out_r;
        frame_err_s  = frame_err_r;
        data_valid_s = 1'b0;
        if (baud_tick) begin
            case (state_r)
                ST_IDLE: begin
                    if (!rx_sync_s) begin
                        state_s    = ST_START;
                        tick_cnt_s = TICK_ZERO;
                    end else begin
                        state_s    = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (tick_cnt_r == TICK_MID) begin
                        tick_cnt_s = TICK_ZERO;
                        if (!rx_sync_s) begin
                            state_s   = ST_DATA;
                            bit_cnt_s = BIT_ZERO;
                        end else begin
                            state_s   = ST_IDLE;
                        end
                    end else begin
                        tick_cnt_s = tick_cnt_r + TICK_ONE;
                    end
                end
                ST_DATA: begin
                    if (tick_cnt_r == TICK_LAST) begin
                        shift_s    = {rx_sync_s, shift_r[DATA_BITS-1:1]};
                        tick_cnt_s = TICK_ZERO;
                        bit_cnt_s  = bit_cnt_r + BIT_ONE;
                        if (bit_cnt_r == BIT_LAST) begin
                            state_s = ST_STOP;
                        end else begin
                            state_s = ST_DATA;
                        end
                    end else begin
                        tick_cnt_s = tick_cnt_r + TICK_ONE;
                    end
                end
                ST_STOP: begin
                    if (tick_cnt_r == TICK_LAST) begin
                        tick_cnt_s = TICK_ZERO;
                        if (rx_sync_s) begin
                            data_out_s   = shift_r;
                            data_valid_s = 1'b1;
                            frame_err_s  = 1'b0;
                            state_s      = ST_IDLE;
                        end else begin
                            frame_err_s  = 1'b1;
                            state_s      = ST_BRK_WAIT;
                        end
                    end else begin
                        tick_cnt_s = tick_cnt_r + TICK_ONE;
                    end
                end
                ST_BRK_WAIT: begin
                    // A held-low line must release before another frame can start.
                    if (rx_sync_s) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_BRK_WAIT;
                    end
                end
                default: begin
                    state_s    = ST_IDLE;
                    tick_cnt_s = TICK_ZERO;
                    bit_cnt_s  = BIT_ZERO;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge inp_clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            tick_cnt_r   <= TICK_ZERO;
            bit_cnt_r    <= BIT_ZERO;
            shift_r      <= {DATA_BITS{1'b0}};
            data_out_r   <= {DATA_BITS{1'b0}};
            data_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            tick_cnt_r   <= tick_cnt_s;
            bit_cnt_r    <= bit_cnt_s;
            shift_r      <= shift_s;
            data_out_r   <= data_out_s;
            data_valid_r <= data_valid_s;
            frame_err_r  <= frame_err_s;
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: an 8N1/16x instance and a 7-bit/8x instance.
module tb_uart_rx_core;

    logic       inp_clk = 1'b0;
    logic       rst;
    logic       baud_tick;
    logic       rx_a, rx_b;
    logic [7:0] data_out_a;
    logic [6:0] data_out_b;
    logic       data_valid_a, data_valid_b;
    logic       frame_err_a, frame_err_b;
    logic       busy_a, busy_b;

    int errors = 0;
    int checks = 0;
    int tick_count = 0;
    logic tick_d = 1'b0;
    logic [7:0] exp_a[$];
    logic [6:0] exp_b[$];
    int vt_a[$];

    uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16)) dut_a (
        .inp_clk(inp_clk), .rst(rst), .baud_tick(baud_tick), .rx_in(rx_a),
        .data_out(data_out_a), .data_valid(data_valid_a),
        .frame_err(frame_err_a), .busy(busy_a)
    );

    uart_rx_core #(.DATA_BITS(7), .OVERSAMPLE(8)) dut_b (
        .inp_clk(inp_clk), .rst(rst), .baud_tick(baud_tick), .rx_in(rx_b),
        .data_out(data_out_b), .data_valid(data_valid_b),
        .frame_err(frame_err_b), .busy(busy_b)
    );

    always #5 inp_clk = ~inp_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One baud tick every four clocks, changed on the falling edge.
    initial begin
        baud_tick = 1'b0;
        forever begin
            repeat (3) @(negedge inp_clk);
            baud_tick = 1'b1;
            @(negedge inp_clk);
            baud_tick = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge inp_clk);
            tick_d = baud_tick;
            if (baud_tick) tick_count++;
        end
    end

    // Monitor: pops the expected byte whenever a receiver presents data.
    initial begin
        logic prev_a, prev_b;
        logic [7:0] ea;
        logic [6:0] eb;
        prev_a = 1'b0;
        prev_b = 1'b0;
        forever begin
            @(negedge inp_clk);
            if (data_valid_a) begin
                if (exp_a.size() == 0) begin
                    check("unexpected_valid_a", 32'd1, 32'd0);
                end else begin
                    ea = exp_a.pop_front();
                    check("data_a", {24'd0, data_out_a}, {24'd0, ea});
                    check("ferr_on_valid_a", {31'd0, frame_err_a}, 32'd0);
                end
                check("latency_a", {31'd0, tick_d}, 32'd1);
                check("pulse_width_a", {31'd0, prev_a}, 32'd0);
                vt_a.push_back(tick_count);
            end
            if (data_valid_b) begin
                if (exp_b.size() == 0) begin
                    check("unexpected_valid_b", 32'd1, 32'd0);
                end else begin
                    eb = exp_b.pop_front();
                    check("data_b", {25'd0, data_out_b}, {25'd0, eb});
                end
                check("latency_b", {31'd0, tick_d}, 32'd1);
                check("pulse_width_b", {31'd0, prev_b}, 32'd0);
            end
            prev_a = data_valid_a;
            prev_b = data_valid_b;
        end
    end

    task automatic drive_bit(input bit sel, input logic v, input int ticks);
        if (sel) rx_b = v;
        else     rx_a = v;
        repeat (ticks * 4) @(negedge inp_clk);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input int nbits,
                              input int os, input logic stop);
        drive_bit(sel, 1'b0, os);
        for (int i = 0; i < nbits; i++) drive_bit(sel, d[i], os);
        drive_bit(sel, stop, os);
    endtask

    initial begin
        rst  = 1'b1;
        rx_a = 1'b1;
        rx_b = 1'b1;
        repeat (4) @(negedge inp_clk);
        check("rst_data_a",  {24'd0, data_out_a}, 32'd0);
        check("rst_valid_a", {31'd0, data_valid_a}, 32'd0);
        check("rst_ferr_a",  {31'd0, frame_err_a}, 32'd0);
        check("rst_busy_a",  {31'd0, busy_a}, 32'd0);
        check("rst_data_b",  {25'd0, data_out_b}, 32'd0);
        rst = 1'b0;
        drive_bit(1'b0, 1'b1, 32);

        // 0xA5, busy sampled inside the data bits
        exp_a.push_back(8'hA5);
        fork
            send_frame(1'b0, 8'hA5, 8, 16, 1'b1);
            begin
                repeat (40 * 4) @(negedge inp_clk);
                check("busy_mid_a", {31'd0, busy_a}, 32'd1);
            end
        join
        drive_bit(1'b0, 1'b1, 32);
        check("busy_idle_a", {31'd0, busy_a}, 32'd0);
        check("ferr_a5", {31'd0, frame_err_a}, 32'd0);

        // back-to-back 0x00 then 0xFF
        vt_a.delete();
        exp_a.push_back(8'h00);
        exp_a.push_back(8'hFF);
        send_frame(1'b0, 8'h00, 8, 16, 1'b1);
        send_frame(1'b0, 8'hFF, 8, 16, 1'b1);
        drive_bit(1'b0, 1'b1, 32);
        check("b2b_count", vt_a.size(), 32'd2);
        if (vt_a.size() == 2) check("b2b_spacing", vt_a[1] - vt_a[0], 32'd160);

        // five-tick low glitch
        drive_bit(1'b0, 1'b0, 3);
        check("glitch_busy", {31'd0, busy_a}, 32'd1);
        drive_bit(1'b0, 1'b0, 2);
        drive_bit(1'b0, 1'b1, 7);
        check("glitch_idle", {31'd0, busy_a}, 32'd0);
        check("glitch_data", {24'd0, data_out_a}, 32'h0000_00FF);
        drive_bit(1'b0, 1'b1, 32);

        // bad stop bit, then a 30-bit break, then 0x55
        send_frame(1'b0, 8'h3C, 8, 16, 1'b0);
        check("brk_ferr", {31'd0, frame_err_a}, 32'd1);
        check("brk_data", {24'd0, data_out_a}, 32'h0000_00FF);
        drive_bit(1'b0, 1'b0, 30 * 16);
        check("brk_busy", {31'd0, busy_a}, 32'd1);
        check("brk_ferr_held", {31'd0, frame_err_a}, 32'd1);
        drive_bit(1'b0, 1'b1, 16);
        check("brk_release", {31'd0, busy_a}, 32'd0);
        exp_a.push_back(8'h55);
        send_frame(1'b0, 8'h55, 8, 16, 1'b1);
        drive_bit(1'b0, 1'b1, 32);
        check("ferr_cleared", {31'd0, frame_err_a}, 32'd0);

        // reset in the middle of data bit 4 of 0x81; the sender also aborts
        drive_bit(1'b0, 1'b0, 16);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, (i == 0) ? 1'b1 : 1'b0, 16);
        drive_bit(1'b0, 1'b0, 8);
        rst = 1'b1;
        @(negedge inp_clk);
        rst  = 1'b0;
        rx_a = 1'b1;
        check("mid_rst_data",  {24'd0, data_out_a}, 32'd0);
        check("mid_rst_valid", {31'd0, data_valid_a}, 32'd0);
        check("mid_rst_ferr",  {31'd0, frame_err_a}, 32'd0);
        check("mid_rst_busy",  {31'd0, busy_a}, 32'd0);
        drive_bit(1'b0, 1'b1, 32);
        exp_a.push_back(8'h81);
        send_frame(1'b0, 8'h81, 8, 16, 1'b1);
        drive_bit(1'b0, 1'b1, 32);
        check("after_rst_data", {24'd0, data_out_a}, 32'h0000_0081);

        // 7 data bits at 8x oversampling
        exp_b.push_back(7'h5A);
        send_frame(1'b1, 8'h5A, 7, 8, 1'b1);
        drive_bit(1'b1, 1'b1, 16);
        check("b_data", {25'd0, data_out_b}, 32'h0000_005A);
        check("b_ferr", {31'd0, frame_err_b}, 32'd0);

        check("pending_a", exp_a.size(), 32'd0);
        check("pending_b", exp_b.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
